// File: rtl/crc_check_serial_if.sv
// Serial codeword stream and check results for crc_check_serial.
// o_err_cnt exists only when CRC_ERR_CNT_EN is defined.
interface crc_check_serial_if #(
  parameter int unsigned DATA_W = 3
);
  logic              i_data;
  logic              i_valid;
  logic              i_sof;
  logic [DATA_W-1:0] o_data;
  logic              o_crc_ok;
  logic              o_crc_err;
  logic              o_done;
  logic              o_busy;
`ifdef CRC_ERR_CNT_EN
  logic [7:0]        o_err_cnt;

  modport master (
    output i_data, i_valid, i_sof,
    input  o_data, o_crc_ok, o_crc_err, o_done, o_busy, o_err_cnt
  );
  modport slave (
    input  i_data, i_valid, i_sof,
    output o_data, o_crc_ok, o_crc_err, o_done, o_busy, o_err_cnt
  );
`else
  modport master (
    output i_data, i_valid, i_sof,
    input  o_data, o_crc_ok, o_crc_err, o_done, o_busy
  );
  modport slave (
    input  i_data, i_valid, i_sof,
    output o_data, o_crc_ok, o_crc_err, o_done, o_busy
  );
`endif
endinterface

// File: rtl/crc_check_serial.sv
// Serial CRC-4 codeword checker: DATA_W payload bits then 4 CRC bits, MSB first.
// Define CRC_ERR_CNT_EN to add the saturating erroneous-codeword counter o_err_cnt.
module crc_check_serial #(
  parameter int unsigned DATA_W = 3,
  parameter logic [4:0]  GPE    = 5'b10111
) (
  input  logic              i_clk,
  input  logic              i_reset,
  crc_check_serial_if.slave bus
);
  localparam int unsigned CNT_W = 5;
  localparam int unsigned CRC_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CRC} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CRC_W-1:0]  rem_q, rem_d, rem_step;
  logic [DATA_W-1:0] pay_q, pay_d, pay_shift;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              start;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? GPE[CRC_W-1:0] : '0);
  endfunction

  // A start bit always begins from a cleared remainder, whether fresh or aborting.
  assign start     = bus.i_valid & bus.i_sof;
  assign rem_step  = crc_step(start ? '0 : rem_q, bus.i_data);
  assign pay_shift = DATA_W'({pay_q, bus.i_data});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    pay_d   = pay_q;
    data_d  = data_q;
    ok_d    = ok_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (start) begin
      rem_d = rem_step;
      pay_d = pay_shift;
      if (DATA_W == 1) begin
        state_d = ST_CRC;
        cnt_d   = '0;
      end else begin
        state_d = ST_DATA;
        cnt_d   = CNT_W'(1);
      end
    end else if (bus.i_valid) begin
      unique case (state_q)
        ST_DATA: begin
          rem_d = rem_step;
          pay_d = pay_shift;
          if (cnt_q == LAST_DATA) begin
            state_d = ST_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_CRC: begin
          rem_d = rem_step;
          if (cnt_q == LAST_CRC) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            data_d  = pay_q;
            ok_d    = (rem_step == '0);
            err_d   = (rem_step != '0);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      pay_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pay_q   <= pay_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_crc_ok  = ok_q;
  assign bus.o_crc_err = err_q;
  assign bus.o_done    = done_q;
  assign bus.o_busy    = busy_q;

`ifdef CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of completions with a non-zero remainder.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_d && err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_crc_check_serial.sv
// Scoreboard bench for crc_check_serial: frame-level polynomial-division model,
// randomized frames with stalls, aborts and back-to-back traffic.
module tb_crc_check_serial;
  localparam int unsigned DW = 3;
  localparam int unsigned CW = DW + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_check_serial_if #(.DATA_W(DW)) bus();
  crc_check_serial #(.DATA_W(DW), .GPE(5'b10111)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          ok;
    int            cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          dones  = 0;
  logic [31:0] cur;
  int          nbits;
  bit          in_frame;
  int          m_errcnt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Remainder of an n-bit polynomial divided by x^4+x^2+x+1.
  function automatic int unsigned poly_mod(input int unsigned v, input int n);
    int unsigned r = v;
    for (int i = n - 1; i >= 4; i--)
      if (r[i]) r = r ^ (32'h17 << (i - 4));
    return r & 32'hF;
  endfunction

  function automatic logic [31:0] make_cw(input int unsigned d);
    return 32'((d << 4) | poly_mod(d << 4, CW));
  endfunction

  function automatic void model_reset();
    in_frame = 0;
    nbits    = 0;
    cur      = '0;
    m_errcnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic b, input logic sof);
    exp_t e;
    if (sof) begin
      in_frame = 1;
      cur      = 32'(b);
      nbits    = 1;
    end else if (in_frame) begin
      cur   = (cur << 1) | 32'(b);
      nbits = nbits + 1;
    end
    if (in_frame && nbits == CW) begin
      e.data = DW'(cur >> 4);
      e.ok   = (poly_mod(cur, CW) == 0);
      if (!e.ok && m_errcnt < 255) m_errcnt++;
      e.cnt = m_errcnt;
      exp_q.push_back(e);
      in_frame = 0;
    end
  endfunction

  task automatic drive(input logic b, input logic sof, input logic v);
    @(negedge clk);
    bus.i_data  = b;
    bus.i_sof   = sof;
    bus.i_valid = v;
    if (v && !rst) model_accept(b, sof);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send_frame(input logic [31:0] cw, input int len, input int g1, input int g2,
                            input int gn, input bit rgap);
    for (int i = 0; i < len; i++) begin
      drive(cw[CW-1-i], i == 0, 1'b1);
      if (i == g1 || i == g2) idle(gn);
      if (rgap && ($urandom % 4 == 0) && i != len - 1) idle(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(bus.o_data), 0);
    chk({tag, "_ok"}, 32'(bus.o_crc_ok), 0);
    chk({tag, "_err"}, 32'(bus.o_crc_err), 0);
    chk({tag, "_done"}, 32'(bus.o_done), 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
`ifdef CRC_ERR_CNT_EN
    chk({tag, "_errcnt"}, 32'(bus.o_err_cnt), 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sof   = 1'b1;
    bus.i_data  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
  endtask

  // Monitor: pops an expectation on every completion and tracks busy every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("busy", 32'(bus.o_busy), 32'(in_frame));
        if (bus.o_done === 1'b1) begin
          dones++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(bus.o_done), 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_data", 32'(bus.o_data), 32'(e.data));
            chk("done_ok", 32'(bus.o_crc_ok), 32'(e.ok));
            chk("done_err", 32'(bus.o_crc_err), 32'(!e.ok));
`ifdef CRC_ERR_CNT_EN
            chk("done_errcnt", 32'(bus.o_err_cnt), 32'(e.cnt));
`endif
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          d0;
    logic [31:0] cw;
    rst         = 1'b1;
    bus.i_data  = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    model_reset();
    do_reset("reset0");

    // Valid bits without a start bit must be ignored.
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    idle(2);

    send_frame(32'b1011100, CW, -1, -1, 0, 0);
    idle(2);
    chk("good_data", 32'(bus.o_data), 32'b101);
    chk("good_ok", 32'(bus.o_crc_ok), 1);

    send_frame(32'b0111001, CW, 1, 4, 2, 0);
    idle(2);
    chk("stall_data", 32'(bus.o_data), 32'b011);
    chk("stall_ok", 32'(bus.o_crc_ok), 1);

    send_frame(32'b1011101, CW, -1, -1, 0, 0);
    idle(2);
    chk("bad_err", 32'(bus.o_crc_err), 1);
    chk("bad_ok", 32'(bus.o_crc_ok), 0);
    chk("bad_data", 32'(bus.o_data), 32'b101);
`ifdef CRC_ERR_CNT_EN
    chk("bad_errcnt", 32'(bus.o_err_cnt), 1);
`endif

    d0 = dones;
    send_frame(32'b101 << 4, 3, -1, -1, 0, 0);
    send_frame(32'b0111001, CW, -1, -1, 0, 0);
    idle(2);
    chk("abort_dones", 32'(dones - d0), 1);
    chk("abort_data", 32'(bus.o_data), 32'b011);

    send_frame(32'b1011100, 4, -1, -1, 0, 0);
    do_reset("reset_mid");
    d0 = dones;
    send_frame(32'b1011100, CW, -1, -1, 0, 0);
    idle(2);
    chk("postrst_dones", 32'(dones - d0), 1);
    chk("postrst_data", 32'(bus.o_data), 32'b101);

    // Random traffic: corruption, stalls, aborts, stray bits, back-to-back.
    for (int n = 0; n < 200; n++) begin
      cw = make_cw($urandom_range(0, (1 << DW) - 1));
      if ($urandom % 2) cw = cw ^ (32'h1 << $urandom_range(0, CW - 1));
      if ($urandom % 8 == 0) send_frame(make_cw($urandom), int'($urandom_range(1, CW - 1)), -1, -1, 0, 1);
      if ($urandom % 8 == 0) drive(1'($urandom), 1'b0, 1'b1);
      send_frame(cw, CW, -1, -1, 0, 1);
      if ($urandom % 3 == 0) idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    do_reset("reset_sat");
    for (int n = 0; n < 260; n++) send_frame(make_cw(n % 8) ^ 32'h1, CW, -1, -1, 0, 0);
    idle(2);
    chk("sat_err", 32'(bus.o_crc_err), 1);
`ifdef CRC_ERR_CNT_EN
    chk("sat_errcnt", 32'(bus.o_err_cnt), 255);
`endif
    idle(2);
    chk("pending", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
